// File: rtl/lzc_stream_gen.sv
// Frame generator for the leading-zero-count stream: emits words whose leading-zero total
// equals the requested count, then a single '1', then LFSR filler bits.
module lzc_stream_gen #(
  parameter int          width      = 8,
  parameter int          word       = 4,
  parameter int          GAP_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             MODE,
  input  logic [8:0]       ZEROS_REQ,
  input  logic             RDY,
  output logic             OVALID,
  output logic [width-1:0] ODATA,
  output logic             OMODE,
  output logic             BUSY,
  output logic             DONE
);

  localparam int WW = $clog2(word + 1);
  localparam int GW = $clog2(GAP_CYCLES);
  localparam logic [8:0]       W9    = 9'(width);
  localparam logic [8:0]       ZMAX  = 9'(width * word);
  localparam logic [WW-1:0]    LAST  = WW'(word - 1);
  localparam logic [GW-1:0]    GLAST = GW'(GAP_CYCLES - 1);
  localparam logic [width-1:0] ONE_W = width'(1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state, state_n;
  logic [8:0]       r, r_n, z, r_a;
  logic             one, one_n, one_a, has_one, last;
  logic [WW-1:0]    widx, widx_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic [15:0]      lfsr, lfsr_n, lfsr_adv;
  logic [width-1:0] odata_n;
  logic             ovalid_n, omode_n, busy_n, done_n;

  // Word for "r zeros still to place": zeros, or the '1' with filler below it, or all filler.
  function automatic logic [width-1:0] gen(logic [8:0] rr, logic oo, logic [15:0] l);
    logic [width-1:0] oh;
    oh = ONE_W << (W9 - 9'd1 - rr);
    if (oo)            gen = l[width-1:0];
    else if (rr >= W9) gen = '0;
    else               gen = oh | (l[width-1:0] & (oh - ONE_W));
  endfunction

  assign lfsr_adv = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    r_n      = r;
    one_n    = one;
    widx_n   = widx;
    gcnt_n   = gcnt;
    lfsr_n   = lfsr;
    odata_n  = ODATA;
    ovalid_n = OVALID;
    omode_n  = OMODE;
    busy_n   = BUSY;
    done_n   = 1'b0;
    z        = (ZEROS_REQ > ZMAX) ? ZMAX : ZEROS_REQ;
    has_one  = !one && (r < W9);
    last     = (OMODE && has_one) || (widx == LAST);
    r_a      = (!one && (r >= W9)) ? r - W9 : r;
    one_a    = one | has_one;
    case (state)
      IDLE: begin
        ovalid_n = 1'b0;
        busy_n   = 1'b0;
        omode_n  = 1'b0;
        // The DONE cycle is still the tail of the old frame; START there is dropped.
        if (START && !DONE) begin
          state_n  = SEND;
          r_n      = z;
          one_n    = 1'b0;
          widx_n   = '0;
          odata_n  = gen(z, 1'b0, lfsr);
          ovalid_n = 1'b1;
          busy_n   = 1'b1;
          omode_n  = MODE;
        end
      end
      SEND: begin
        if (RDY) begin
          lfsr_n = lfsr_adv;
          if (last) begin
            state_n  = GAP;
            ovalid_n = 1'b0;
            odata_n  = '0;
            gcnt_n   = '0;
          end else begin
            r_n     = r_a;
            one_n   = one_a;
            widx_n  = widx + WW'(1);
            odata_n = gen(r_a, one_a, lfsr_adv);
          end
        end
      end
      GAP: begin
        if (gcnt == GLAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          omode_n = 1'b0;
        end else begin
          gcnt_n = gcnt + GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r      <= '0;
      one    <= 1'b0;
      widx   <= '0;
      gcnt   <= '0;
      lfsr   <= LFSR_SEED;
      ODATA  <= '0;
      OVALID <= 1'b0;
      OMODE  <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      r      <= r_n;
      one    <= one_n;
      widx   <= widx_n;
      gcnt   <= gcnt_n;
      lfsr   <= lfsr_n;
      ODATA  <= odata_n;
      OVALID <= ovalid_n;
      OMODE  <= omode_n;
      BUSY   <= busy_n;
      DONE   <= done_n;
    end
  end

endmodule

// File: tb/tb_lzc_stream_gen.sv
// Bench for lzc_stream_gen: directed and random frames against an arithmetic word model.
module tb_lzc_stream_gen;
  localparam int          W    = 8;
  localparam int          N    = 4;
  localparam int          G    = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic         CLK = 1'b0;
  logic         RST, START, MODE, RDY;
  logic [8:0]   ZEROS_REQ;
  logic         OVALID, OMODE, BUSY, DONE;
  logic [W-1:0] ODATA;

  int          vecs = 0;
  int          errs = 0;
  logic [15:0] mlfsr;

  lzc_stream_gen #(.width(W), .word(N), .GAP_CYCLES(G), .LFSR_SEED(SEED)) dut (
    .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .ZEROS_REQ(ZEROS_REQ), .RDY(RDY),
    .OVALID(OVALID), .ODATA(ODATA), .OMODE(OMODE), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] lstep(logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Word k of a frame with z leading zeros, using that word's LFSR state l.
  function automatic logic [W-1:0] model_word(int z, int k, logic [15:0] l);
    int p, oh;
    if (z >= (k + 1) * W) return '0;
    if (z >= k * W) begin
      p  = z - k * W;
      oh = 1 << (W - 1 - p);
      return W'(oh | (int'(l) & (oh - 1)));
    end
    return l[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // rdy_mode: 0 = always ready, 1 = random stalls, 2 = three stall cycles on word 1.
  // rst_after >= 0: assert RST once that many words have transferred.
  task automatic run_frame(input int zr, input bit m, input int rdy_mode,
                           input bit poke, input int rst_after);
    int z, nw, i, cyc, stalls;
    logic [W-1:0] exp[$];
    z  = (zr > W * N) ? W * N : zr;
    nw = m ? (((z / W + 1) < N) ? z / W + 1 : N) : N;
    for (int k = 0; k < nw; k++) begin
      exp.push_back(model_word(z, k, mlfsr));
      mlfsr = lstep(mlfsr);
    end
    @(negedge CLK);
    START = 1'b1; MODE = m; ZEROS_REQ = 9'(zr); RDY = 1'b1;
    @(negedge CLK);
    START = 1'b0; MODE = ~m; ZEROS_REQ = 9'($urandom_range(0, 511));
    chk("first_latency", OVALID, 1);
    i = 0; cyc = 0; stalls = 0;
    while (i < nw && cyc < 200) begin
      cyc++;
      chk("ovalid_send", OVALID, 1);
      chk("odata", ODATA, exp[i]);
      chk("omode", OMODE, m);
      chk("busy_send", BUSY, 1);
      chk("done_send", DONE, 0);
      if (rst_after >= 0 && i == rst_after) begin
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        mlfsr = SEED;
        chk("rst_ovalid", OVALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_omode", OMODE, 0);
        for (int c = 0; c < 8; c++) begin
          chk("rst_no_done", DONE, 0);
          @(negedge CLK);
        end
        return;
      end
      if (rdy_mode == 1)                                RDY = ($urandom_range(0, 3) != 0);
      else if (rdy_mode == 2 && i == 1 && stalls < 3) begin RDY = 1'b0; stalls++; end
      else                                              RDY = 1'b1;
      START = poke && (cyc == 2);
      if (RDY) i++;
      @(negedge CLK);
    end
    if (i < nw) chk("send_timeout", 0, 1);
    START = 1'b0; RDY = 1'b1;
    for (int g = 0; g < G; g++) begin
      chk("gap_ovalid", OVALID, 0);
      chk("gap_done", DONE, 0);
      chk("gap_busy", BUSY, 1);
      @(negedge CLK);
    end
    chk("done_pulse", DONE, 1);
    chk("done_busy", BUSY, 0);
    chk("done_ovalid", OVALID, 0);
    START = 1'b1; ZEROS_REQ = 9'd0;
    @(negedge CLK);
    START = 1'b0;
    chk("done_one_cycle", DONE, 0);
    chk("start_on_done_ignored", OVALID, 0);
    chk("idle_busy", BUSY, 0);
    chk("idle_omode", OMODE, 0);
  endtask

  task automatic do_reset;
    @(negedge CLK);
    RST = 1'b1; START = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    mlfsr = SEED;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; MODE = 1'b0; RDY = 1'b1; ZEROS_REQ = '0;
    repeat (2) @(negedge CLK);
    chk("rst_ovalid", OVALID, 0);
    chk("rst_odata", ODATA, 0);
    chk("rst_omode", OMODE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    RST = 1'b0;
    mlfsr = SEED;

    run_frame(11, 1'b0, 0, 1'b0, -1);
    run_frame(11, 1'b1, 0, 1'b0, -1);
    run_frame(40, 1'b0, 0, 1'b0, -1);
    run_frame(40, 1'b1, 0, 1'b0, -1);
    run_frame(32, 1'b1, 0, 1'b0, -1);
    run_frame(0,  1'b1, 0, 1'b0, -1);
    run_frame(11, 1'b0, 2, 1'b1, -1);
    run_frame(7,  1'b1, 0, 1'b0, -1);
    run_frame(8,  1'b1, 0, 1'b0, -1);
    for (int n = 0; n < 25; n++)
      run_frame(int'($urandom_range(0, 45)), 1'($urandom_range(0, 1)), 1,
                1'($urandom_range(0, 1)), -1);

    do_reset();
    run_frame(11, 1'b0, 0, 1'b0, -1);
    run_frame(11, 1'b0, 0, 1'b0, 2);
    run_frame(11, 1'b0, 0, 1'b0, -1);
    run_frame(19, 1'b1, 1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
